addsub_arbiter: RTL

//  Shares one combinational 8-bit adder/subtractor (a sub input XORs B and feeds the carry-in)

---
 rtl/addsub_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared combinational adder/subtractor: arbitrates,
// drives the unit for one cycle, and returns the tagged result on a valid/ready port.
module addsub_arbiter #(
   parameter int WIDTH     = 8,
   parameter int FIXED_PRI = 0,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_cin,
   input  logic [WIDTH-1:0] au_s,
   input  logic             au_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             op_id_q, op_id_d;
   logic [WIDTH-1:0] au_a_q, au_a_d;
   logic [WIDTH-1:0] au_b_q, au_b_d;
   logic             au_cin_q, au_cin_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             grant_s;
   logic             accept_s;
   logic [WIDTH-1:0] bx_s;
   logic             ovf_s;

   // Grant selection: a lone requester wins; a tie goes round-robin or to requester 0.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         if (FIXED_PRI != 0) begin
            grant_s = 1'b0;
         end else begin
            grant_s = ~last_grant_q;
         end
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Ready is gated by rst_n so every output reads 0 while reset is held.
   assign req0_ready = rst_n & (state_q == IDLE) & ~grant_s & req0_valid;
   assign req1_ready = rst_n & (state_q == IDLE) &  grant_s & req1_valid;
   assign accept_s   = req0_ready | req1_ready;

   // Overflow is judged against the effective B operand the unit actually added.
   assign bx_s  = au_b_q ^ {WIDTH{au_cin_q}};
   assign ovf_s = (au_a_q[WIDTH-1] == bx_s[WIDTH-1]) & (au_s[WIDTH-1] != au_a_q[WIDTH-1]);

   // Next-state logic; the au_* registers double as the latched operands and are zero outside EXEC.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_id_d      = op_id_q;
      au_a_d       = au_a_q;
      au_b_d       = au_b_q;
      au_cin_d     = au_cin_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_s_d      = rsp_s_q;
      rsp_cout_d   = rsp_cout_q;
      rsp_ovf_d    = rsp_ovf_q;
      op_count_d   = op_count_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d      = EXEC;
               op_id_d      = grant_s;
               last_grant_d = grant_s;
               au_a_d       = grant_s ? req1_a   : req0_a;
               au_b_d       = grant_s ? req1_b   : req0_b;
               au_cin_d     = grant_s ? req1_sub : req0_sub;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_id_q;
            rsp_s_d     = au_s;
            rsp_cout_d  = au_cout;
            rsp_ovf_d   = ovf_s;
            au_a_d      = {WIDTH{1'b0}};
            au_b_d      = {WIDTH{1'b0}};
            au_cin_d    = 1'b0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            au_a_d      = {WIDTH{1'b0}};
            au_b_d      = {WIDTH{1'b0}};
            au_cin_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_id_q      <= 1'b0;
         au_a_q       <= {WIDTH{1'b0}};
         au_b_q       <= {WIDTH{1'b0}};
         au_cin_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_s_q      <= {WIDTH{1'b0}};
         rsp_cout_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         op_count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_id_q      <= op_id_d;
         au_a_q       <= au_a_d;
         au_b_q       <= au_b_d;
         au_cin_q     <= au_cin_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_s_q      <= rsp_s_d;
         rsp_cout_q   <= rsp_cout_d;
         rsp_ovf_q    <= rsp_ovf_d;
         op_count_q   <= op_count_d;
      end
   end

   assign au_a      = au_a_q;
   assign au_b      = au_b_q;
   assign au_cin    = au_cin_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign op_count  = op_count_q;

endmodule
